dm_arbiter: RTL and testbench

Two-master arbiter for the single data-memory port of the pipelined MIPS core. It shares the word-addressed, byte-enabled data memory between the CPU M-stage (master 0) and a DMA/debug master (master 1). Single-beat accesses use round-robin arbitration, and locked bursts carry a bounded hold limit. It drives the memory-side `m_data_addr`/`m_data_wdata`/`m_data_byteen` signals and routes `m_data_rdata` back to the masters.

---
 rtl/dm_arbiter.sv | 135 +++++++++++++
 tb/tb_dm_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the MIPS data-memory port: CPU M-stage (m0) and DMA/debug (m1).
// Zero-latency grant, round-robin ties, locked bursts with a bounded hold and a conflict counter.
module dm_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m0_byteen,
    input  logic [3:0]        m1_byteen,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic [31:0]       s_rdata,
    output logic [31:0]       m_data_addr,
    output logic [31:0]       m_data_wdata,
    output logic [3:0]        m_data_byteen,
    input  logic [31:0]       m_data_rdata,
    output logic [1:0]        owner,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t             r_owner;
    owner_t             w_ownerNext;
    logic               r_pri;
    logic               w_priNext;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic [HOLD_W-1:0]  w_holdNext;
    logic [HOLD_W-1:0]  w_holdInc;
    logic [CNT_W-1:0]   r_conflictCnt;
    logic [CNT_W-1:0]   w_conflictNext;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_holdFull;
    logic               w_bothReq;

    assign w_bothReq  = m0_req & m1_req;
    assign w_holdFull = (r_holdCnt == HOLD_W'(MAX_HOLD));
    assign w_holdInc  = w_holdFull ? r_holdCnt : r_holdCnt + HOLD_W'(1);

    // An exhausted owner yields to a waiting non-owner; otherwise the owner wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_owner)
                OWN_M0: begin
                    if (m0_req && !(m1_req && w_holdFull)) w_gnt0 = 1'b1;
                    else if (m1_req)                       w_gnt1 = 1'b1;
                end
                OWN_M1: begin
                    if (m1_req && !(m0_req && w_holdFull)) w_gnt1 = 1'b1;
                    else if (m0_req)                       w_gnt0 = 1'b1;
                end
                default: begin
                    if (w_bothReq) begin
                        w_gnt0 = ~r_pri;
                        w_gnt1 = r_pri;
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_ownerNext    = r_owner;
        w_priNext      = r_pri;
        w_holdNext     = r_holdCnt;
        w_conflictNext = r_conflictCnt;
        if (w_gnt0) begin
            if (m0_lock) begin
                w_ownerNext = OWN_M0;
                w_holdNext  = (r_owner == OWN_M0) ? w_holdInc : HOLD_W'(1);
            end else begin
                w_ownerNext = OWN_NONE;
                w_holdNext  = '0;
                w_priNext   = 1'b1;
            end
        end else if (w_gnt1) begin
            if (m1_lock) begin
                w_ownerNext = OWN_M1;
                w_holdNext  = (r_owner == OWN_M1) ? w_holdInc : HOLD_W'(1);
            end else begin
                w_ownerNext = OWN_NONE;
                w_holdNext  = '0;
                w_priNext   = 1'b0;
            end
        end
        if (w_bothReq && (r_conflictCnt != '1)) begin
            w_conflictNext = r_conflictCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= OWN_NONE;
            r_pri         <= 1'b0;
            r_holdCnt     <= '0;
            r_conflictCnt <= '0;
        end else begin
            r_owner       <= w_ownerNext;
            r_pri         <= w_priNext;
            r_holdCnt     <= w_holdNext;
            r_conflictCnt <= w_conflictNext;
        end
    end

    assign m0_gnt        = w_gnt0;
    assign m1_gnt        = w_gnt1;
    assign m_data_addr   = w_gnt0 ? m0_addr   : (w_gnt1 ? m1_addr   : 32'd0);
    assign m_data_wdata  = w_gnt0 ? m0_wdata  : (w_gnt1 ? m1_wdata  : 32'd0);
    assign m_data_byteen = w_gnt0 ? m0_byteen : (w_gnt1 ? m1_byteen : 4'd0);
    assign s_rdata       = m_data_rdata;
    assign owner         = r_owner;
    assign conflict_cnt  = r_conflictCnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model and a shadow copy of memory.
module tb_dm_arbiter;

    localparam int MAXH = 3;
    localparam int CW   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt;
    logic [31:0] s_rdata, m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic [1:0]  owner;
    logic [CW-1:0] conflict_cnt;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];

    int testCount = 0;
    int failCount = 0;

    // reference model state
    int mOwner, mPri, mHold, mCnt, lastWin;
    logic        obsG0, obsG1;
    logic [3:0]  obsBe;
    logic [31:0] obsRdata;

    dm_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_byteen(m0_byteen), .m1_byteen(m1_byteen),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .s_rdata(s_rdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
        .owner(owner), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with byte-lane writes, read combinationally.
    assign m_data_rdata = mem[m_data_addr[9:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) mem[m_data_addr[9:2]][b*8 +: 8] <= m_data_wdata[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic q0, input logic l0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [3:0] b0,
                                 input logic q1, input logic l1, input logic [31:0] a1,
                                 input logic [31:0] d1, input logic [3:0] b1);
        reset = r;
        m0_req = q0; m0_lock = l0; m0_addr = a0; m0_wdata = d0; m0_byteen = b0;
        m1_req = q1; m1_lock = l1; m1_addr = a1; m1_wdata = d1; m1_byteen = b1;
    endtask

    // Winner: sole requester takes it; on a tie an unexhausted owner keeps it,
    // an exhausted owner loses it, and with no owner the priority bit decides.
    function automatic int winner();
        if (reset) return -1;
        if (m0_req && m1_req) begin
            if (mOwner == 1) return (mHold >= MAXH) ? 1 : 0;
            if (mOwner == 2) return (mHold >= MAXH) ? 0 : 1;
            return mPri;
        end
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic checkOutput();
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        lastWin = winner();
        ea = (lastWin == 0) ? m0_addr   : (lastWin == 1) ? m1_addr   : 32'd0;
        ed = (lastWin == 0) ? m0_wdata  : (lastWin == 1) ? m1_wdata  : 32'd0;
        eb = (lastWin == 0) ? m0_byteen : (lastWin == 1) ? m1_byteen : 4'd0;
        obsG0 = m0_gnt; obsG1 = m1_gnt; obsBe = m_data_byteen; obsRdata = s_rdata;
        check("gnt0", 32'(m0_gnt), 32'(lastWin == 0));
        check("gnt1", 32'(m1_gnt), 32'(lastWin == 1));
        check("addr", m_data_addr, ea);
        check("wdata", m_data_wdata, ed);
        check("byteen", 32'(m_data_byteen), 32'(eb));
        check("rdata", s_rdata, shadow[ea[9:2]]);
        check("owner", 32'(owner), 32'(mOwner));
        check("conflictCnt", 32'(conflict_cnt), 32'(mCnt));
    endtask

    task automatic updateModel();
        int lk;
        if (reset) begin
            mOwner = 0; mPri = 0; mHold = 0; mCnt = 0;
            return;
        end
        if (m0_req && m1_req && mCnt < (1 << CW) - 1) mCnt++;
        if (lastWin < 0) return;
        for (int b = 0; b < 4; b++)
            if ((lastWin == 0) ? m0_byteen[b] : m1_byteen[b])
                shadow[((lastWin == 0) ? m0_addr[9:2] : m1_addr[9:2])][b*8 +: 8] =
                    (lastWin == 0) ? m0_wdata[b*8 +: 8] : m1_wdata[b*8 +: 8];
        lk = (lastWin == 0) ? int'(m0_lock) : int'(m1_lock);
        if (lk != 0) begin
            mHold  = (mOwner == lastWin + 1) ? ((mHold + 1 > MAXH) ? MAXH : mHold + 1) : 1;
            mOwner = lastWin + 1;
        end else begin
            mOwner = 0; mHold = 0; mPri = 1 - lastWin;
        end
    endtask

    task automatic runCycle(input logic r,
                            input logic q0, input logic l0, input logic [31:0] a0,
                            input logic [31:0] d0, input logic [3:0] b0,
                            input logic q1, input logic l1, input logic [31:0] a1,
                            input logic [31:0] d1, input logic [3:0] b1);
        applyStimulus(r, q0, l0, a0, d0, b0, q1, l1, a1, d1, b1);
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        runCycle(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        pend0, pend1;
        logic        q0, l0, q1, l1;
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  b0, b1;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        mOwner = 0; mPri = 0; mHold = 0; mCnt = 0; lastWin = -1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // reset state
        idle(1);
        runCycle(1, 1, 1, 32'h4, 32'h1, 4'hF, 1, 1, 32'h8, 32'h2, 4'hF);
        check("rstOwner", 32'(owner), 32'd0);
        check("rstCnt", 32'(conflict_cnt), 32'd0);

        // uncontended write then read-back
        runCycle(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        check("wrGnt", 32'(obsG0), 32'd1);
        check("wrBe", 32'(obsBe), 32'hF);
        runCycle(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0);
        check("rdBack", obsRdata, 32'hDEADBEEF);

        // tie round-robin from a fresh reset
        idle(1);
        for (int i = 0; i < 4; i++) begin
            runCycle(0, 1, 0, 32'h40, 32'h0, 4'h0, 1, 0, 32'h44, 32'h0, 4'h0);
            check("tieOrder", 32'(obsG1), 32'(i % 2));
        end
        check("tieCnt", 32'(conflict_cnt), 32'd4);

        // byte write through m1
        runCycle(0, 1, 0, 32'h20, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        runCycle(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h00AB0000, 4'b0100);
        runCycle(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0);
        check("byteWrite", obsRdata, 32'h11AB3344);

        // locked burst with forced release after MAX_HOLD beats
        idle(1);
        runCycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h0, 4'h0);
        check("burst1", 32'(obsG1), 32'd1);
        for (int i = 0; i < 2; i++) begin
            runCycle(0, 1, 0, 32'h84, 32'h0, 4'h0, 1, 1, 32'h80, 32'h0, 4'h0);
            check("burstHold", 32'(obsG1), 32'd1);
        end
        runCycle(0, 1, 0, 32'h84, 32'h0, 4'h0, 1, 1, 32'h80, 32'h0, 4'h0);
        check("forcedRelease", 32'(obsG0), 32'd1);
        runCycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h0, 4'h0);
        check("burstResume", 32'(obsG1), 32'd1);
        runCycle(0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h0, 4'h0);

        // reset in the middle of an m1 burst
        runCycle(0, 0, 0, 0, 0, 0, 1, 1, 32'hC0, 32'h5, 4'hF);
        check("midOwner", 32'(owner), 32'd2);
        runCycle(1, 1, 0, 32'hC4, 32'h6, 4'hF, 1, 1, 32'hC0, 32'h5, 4'hF);
        check("midRstGnt", 32'({obsG0, obsG1}), 32'd0);
        check("midRstBe", 32'(obsBe), 32'd0);
        runCycle(0, 1, 0, 32'hC4, 32'h6, 4'hF, 1, 1, 32'hC0, 32'h5, 4'hF);
        check("postRstGnt", 32'(obsG0), 32'd1);
        check("postRstOwner", 32'(owner), 32'd0);

        // saturation of the conflict counter
        idle(1);
        for (int i = 0; i < 20; i++)
            runCycle(0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 0, 32'h104, 32'h0, 4'h0);
        check("saturate", 32'(conflict_cnt), 32'd15);

        // randomized traffic; refused masters hold request and payload
        pend0 = 0; pend1 = 0;
        q0 = 0; l0 = 0; a0 = 0; d0 = 0; b0 = 0;
        q1 = 0; l1 = 0; a1 = 0; d1 = 0; b1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0) begin
                q0 = ($urandom_range(0, 3) != 0); l0 = ($urandom_range(0, 2) == 0);
                a0 = 32'($urandom_range(0, 255)) << 2; d0 = $urandom;
                b0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if (!pend1) begin
                q1 = ($urandom_range(0, 2) != 0); l1 = ($urandom_range(0, 1) == 0);
                a1 = 32'($urandom_range(0, 255)) << 2; d1 = $urandom;
                b1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            runCycle(($urandom_range(0, 59) == 0), q0, l0, a0, d0, b0, q1, l1, a1, d1, b1);
            pend0 = q0 && !obsG0;
            pend1 = q1 && !obsG1;
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
